alu_issue_stage: RTL and testbench

//  Upstream issue/capture stage for the 16-bit combinational ALU in the multi-cycle datapath.

---
 rtl/alu_issue_stage.sv | 179 +++++++++++++++++
 tb/tb_alu_issue_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//
// Issue/capture stage that sits in front of the 16-bit combinational ALU in
// the multi-cycle datapath. One operation is taken per request handshake. The
// stage picks the operands, registers them with the opcode for the ALU, waits
// one cycle for the ALU to settle, then captures the result (and the branch
// decision) and holds it on the result handshake until the consumer takes it.
//
// Ports
//   clk            single clock, rising edge
//   rst_n          asynchronous active-low reset
//   req_valid      request present
//   req_ready      stage can accept a request (high only in IDLE)
//   req_funct      0 ADD,1 SUB,2 SLL,3 SRL,4 OR,5 AND,6 BEQ,7 BNE, 8-15 illegal
//   req_srca_sel   0: A = rs1, 1: A = pc
//   req_srcb_sel   0: B = rs2, 1: B = imm
//   rs1, rs2       register-file read data
//   imm            sign-extended immediate
//   pc             current PC
//   alu_a, alu_b   registered ALU operands
//   alu_op         registered ALU opcode (0-5)
//   alu_out        ALU result
//   alu_zero       ALU zero flag
//   res_valid      result held valid
//   res_ready      consumer accepts result
//   res_data       captured result
//   res_taken      branch taken (BEQ/BNE only)
//   res_err        request carried an illegal funct

module alu_issue_stage #(
  parameter int WIDTH      = 16,
  parameter int SHAMT_BITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_funct,
  input  logic             req_srca_sel,
  input  logic             req_srcb_sel,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_taken,
  output logic             res_err
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_SLL = 3'd2;
  localparam logic [2:0] OP_SRL = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic             accept;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] shamt_b;

  logic [2:0] dec_op;
  logic       dec_shift;
  logic       dec_branch;
  logic       dec_bne;
  logic       dec_err;

  logic       kind_branch;
  logic       kind_bne;
  logic       kind_err;

  // Only IDLE takes new work, so the request side is ready exactly there.
  // A request that arrives while an op is in flight just waits on the requester.
  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;

  // Operand muxes. Shifts only look at the low SHAMT_BITS of B, so the upper
  // bits are cleared before the operand reaches the ALU.
  assign src_a   = req_srca_sel ? pc  : rs1;
  assign src_b   = req_srcb_sel ? imm : rs2;
  assign shamt_b = {{(WIDTH-SHAMT_BITS){1'b0}}, src_b[SHAMT_BITS-1:0]};

  // Translate the request funct into an ALU opcode plus the flags needed later
  // to interpret the result. Branches compare by subtracting; illegal codes
  // still run an ADD so the handshake completes, but the result is masked off.
  always_comb begin
    dec_op     = OP_ADD;
    dec_shift  = 1'b0;
    dec_branch = 1'b0;
    dec_bne    = 1'b0;
    dec_err    = 1'b0;
    case (req_funct)
      4'd0: dec_op = OP_ADD;
      4'd1: dec_op = OP_SUB;
      4'd2: begin dec_op = OP_SLL; dec_shift = 1'b1; end
      4'd3: begin dec_op = OP_SRL; dec_shift = 1'b1; end
      4'd4: dec_op = OP_OR;
      4'd5: dec_op = OP_AND;
      4'd6: begin dec_op = OP_SUB; dec_branch = 1'b1; end
      4'd7: begin dec_op = OP_SUB; dec_branch = 1'b1; dec_bne = 1'b1; end
      default: begin dec_op = OP_ADD; dec_err = 1'b1; end
    endcase
  end

  // State register. Reset can land at any point, including mid-operation,
  // and simply abandons whatever was in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: accept -> one settle cycle in EXEC -> hold in DONE
  // until the consumer takes the result.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)    state_next = EXEC;
      EXEC:                   state_next = DONE;
      DONE:    if (res_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Datapath registers. ALU inputs are loaded on accept and then left alone
  // until the next accept. The result is captured at the end of EXEC, when the
  // combinational ALU has had a full cycle to settle. Draining only drops
  // res_valid; the captured values stay visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= OP_ADD;
      kind_branch <= 1'b0;
      kind_bne    <= 1'b0;
      kind_err    <= 1'b0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_taken   <= 1'b0;
      res_err     <= 1'b0;
    end else begin
      if (accept) begin
        alu_a       <= src_a;
        alu_b       <= dec_shift ? shamt_b : src_b;
        alu_op      <= dec_op;
        kind_branch <= dec_branch;
        kind_bne    <= dec_bne;
        kind_err    <= dec_err;
      end
      if (state == EXEC) begin
        res_valid <= 1'b1;
        res_data  <= kind_err ? '0 : alu_out;
        res_taken <= kind_branch & (kind_bne ? ~alu_zero : alu_zero);
        res_err   <= kind_err;
      end else if ((state == DONE) && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage
//
// Directed bench for alu_issue_stage. A behavioural ALU closes the loop from
// alu_a/alu_b/alu_op back to alu_out/alu_zero. Every expected value below is
// a hand-computed constant. Outputs are sampled on the falling clock edge.

module tb_alu_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_funct;
  logic        req_srca_sel;
  logic        req_srcb_sel;
  logic [15:0] rs1;
  logic [15:0] rs2;
  logic [15:0] imm;
  logic [15:0] pc;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_op;
  logic [15:0] alu_out;
  logic        alu_zero;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        res_taken;
  logic        res_err;

  int numChecks = 0;
  int numFails  = 0;

  alu_issue_stage #(.WIDTH(16), .SHAMT_BITS(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_funct    (req_funct),
    .req_srca_sel (req_srca_sel),
    .req_srcb_sel (req_srcb_sel),
    .rs1          (rs1),
    .rs2          (rs2),
    .imm          (imm),
    .pc           (pc),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_out      (alu_out),
    .alu_zero     (alu_zero),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_taken    (res_taken),
    .res_err      (res_err)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the downstream combinational ALU.
  always_comb begin
    alu_out = 16'h0000;
    case (alu_op)
      3'd0: alu_out = alu_a + alu_b;
      3'd1: alu_out = alu_a - alu_b;
      3'd2: alu_out = alu_a << alu_b[3:0];
      3'd3: alu_out = alu_a >> alu_b[3:0];
      3'd4: alu_out = alu_a | alu_b;
      3'd5: alu_out = alu_a & alu_b;
      default: alu_out = 16'h0000;
    endcase
  end
  assign alu_zero = (alu_out == 16'h0000);

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    numChecks++;
    if (observed !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one request onto the input side and raise req_valid.
  task automatic applyStimulus(input logic [3:0] funct, input logic sa, input logic sb,
                               input logic [15:0] r1, input logic [15:0] r2,
                               input logic [15:0] im, input logic [15:0] p);
    req_funct    = funct;
    req_srca_sel = sa;
    req_srcb_sel = sb;
    rs1          = r1;
    rs2          = r2;
    imm          = im;
    pc           = p;
    req_valid    = 1'b1;
  endtask

  // One full transaction from the falling edge: accept, settle, capture, drain.
  task automatic runOp(input string tag, input logic [3:0] funct, input logic sa,
                       input logic sb, input logic [15:0] r1, input logic [15:0] r2,
                       input logic [15:0] im, input logic [15:0] p,
                       input logic [15:0] expA, input logic [15:0] expB,
                       input logic [2:0] expOp, input logic [15:0] expData,
                       input logic expTaken, input logic expErr);
    checkOutput({tag, "_ready_idle"}, 32'(req_ready), 32'd1);
    applyStimulus(funct, sa, sb, r1, r2, im, p);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput({tag, "_ready_exec"}, 32'(req_ready), 32'd0);
    checkOutput({tag, "_valid_exec"}, 32'(res_valid), 32'd0);
    checkOutput({tag, "_alu_a"},      32'(alu_a), 32'(expA));
    checkOutput({tag, "_alu_b"},      32'(alu_b), 32'(expB));
    checkOutput({tag, "_alu_op"},     32'(alu_op), 32'(expOp));
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "_valid"},      32'(res_valid), 32'd1);
    checkOutput({tag, "_data"},       32'(res_data), 32'(expData));
    checkOutput({tag, "_taken"},      32'(res_taken), 32'(expTaken));
    checkOutput({tag, "_err"},        32'(res_err), 32'(expErr));
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    checkOutput({tag, "_valid_drained"}, 32'(res_valid), 32'd0);
    checkOutput({tag, "_ready_drained"}, 32'(req_ready), 32'd1);
    checkOutput({tag, "_data_kept"},     32'(res_data), 32'(expData));
  endtask

  initial begin
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_funct    = 4'd0;
    req_srca_sel = 1'b0;
    req_srcb_sel = 1'b0;
    rs1          = 16'h0000;
    rs2          = 16'h0000;
    imm          = 16'h0000;
    pc           = 16'h0000;
    res_ready    = 1'b0;

    // Reset values.
    #12;
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("rst_alu_a",     32'(alu_a), 32'd0);
    checkOutput("rst_alu_op",    32'(alu_op), 32'd0);
    checkOutput("rst_res_data",  32'(res_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // No request: nothing happens.
    @(posedge clk);
    @(negedge clk);
    checkOutput("idle_ready", 32'(req_ready), 32'd1);
    checkOutput("idle_valid", 32'(res_valid), 32'd0);

    //        tag     fn  sa    sb    rs1      rs2      imm      pc       expA     expB     op    data     tk    err
    runOp("add",    4'd0, 1'b0, 1'b0, 16'h0003, 16'h0004, 16'h0000, 16'h0000, 16'h0003, 16'h0004, 3'd0, 16'h0007, 1'b0, 1'b0);
    runOp("sub_pc", 4'd1, 1'b1, 1'b1, 16'h5555, 16'h6666, 16'hFFFE, 16'h0010, 16'h0010, 16'hFFFE, 3'd1, 16'h0012, 1'b0, 1'b0);
    runOp("sub_wr", 4'd1, 1'b0, 1'b0, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 3'd1, 16'hFFFF, 1'b0, 1'b0);
    runOp("sll",    4'd2, 1'b0, 1'b0, 16'h0001, 16'h0013, 16'h0000, 16'h0000, 16'h0001, 16'h0003, 3'd2, 16'h0008, 1'b0, 1'b0);
    runOp("srl",    4'd3, 1'b0, 1'b0, 16'h8000, 16'h000F, 16'h0000, 16'h0000, 16'h8000, 16'h000F, 3'd3, 16'h0001, 1'b0, 1'b0);
    runOp("or",     4'd4, 1'b0, 1'b0, 16'h00F0, 16'h0F0F, 16'h0000, 16'h0000, 16'h00F0, 16'h0F0F, 3'd4, 16'h0FFF, 1'b0, 1'b0);
    runOp("and",    4'd5, 1'b0, 1'b0, 16'hFF00, 16'h0FF0, 16'h0000, 16'h0000, 16'hFF00, 16'h0FF0, 3'd5, 16'h0F00, 1'b0, 1'b0);
    runOp("beq",    4'd6, 1'b0, 1'b0, 16'h1234, 16'h1234, 16'h0000, 16'h0000, 16'h1234, 16'h1234, 3'd1, 16'h0000, 1'b1, 1'b0);
    runOp("bne_eq", 4'd7, 1'b0, 1'b0, 16'h1234, 16'h1234, 16'h0000, 16'h0000, 16'h1234, 16'h1234, 3'd1, 16'h0000, 1'b0, 1'b0);
    runOp("bne_ne", 4'd7, 1'b0, 1'b0, 16'h1234, 16'h1235, 16'h0000, 16'h0000, 16'h1234, 16'h1235, 3'd1, 16'hFFFF, 1'b1, 1'b0);
    runOp("illegal",4'hA, 1'b0, 1'b0, 16'h0005, 16'h0006, 16'h0000, 16'h0000, 16'h0005, 16'h0006, 3'd0, 16'h0000, 1'b0, 1'b1);

    // Back-pressure: result held while res_ready is low, a waiting request
    // is ignored until the result drains.
    applyStimulus(4'd0, 1'b0, 1'b0, 16'h0100, 16'h0023, 16'h0000, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(4'd1, 1'b0, 1'b0, 16'h0050, 16'h0010, 16'h0000, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_valid", 32'(res_valid), 32'd1);
      checkOutput("stall_data",  32'(res_data), 32'h0123);
      checkOutput("stall_ready", 32'(req_ready), 32'd0);
      checkOutput("stall_alu_a", 32'(alu_a), 32'h0100);
      @(posedge clk);
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    checkOutput("drain_valid", 32'(res_valid), 32'd0);
    checkOutput("drain_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("second_accept_ready", 32'(req_ready), 32'd0);
    checkOutput("second_alu_a",        32'(alu_a), 32'h0050);
    checkOutput("second_alu_op",       32'(alu_op), 32'd1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("second_data", 32'(res_data), 32'h0040);
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;

    // Asynchronous reset in the middle of EXEC.
    applyStimulus(4'd0, 1'b0, 1'b0, 16'h1111, 16'h2222, 16'h0000, 16'h0000);
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    checkOutput("arst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("arst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("arst_alu_a",     32'(alu_a), 32'd0);
    checkOutput("arst_alu_b",     32'(alu_b), 32'd0);
    checkOutput("arst_res_data",  32'(res_data), 32'd0);
    checkOutput("arst_res_taken", 32'(res_taken), 32'd0);
    checkOutput("arst_res_err",   32'(res_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("post_rst_valid", 32'(res_valid), 32'd0);
      checkOutput("post_rst_ready", 32'(req_ready), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
